// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the shared data-memory port.
// The slave modport is the arbiter's view; the master modport is the view of the
// requesters plus the memory that surround it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_read_data,
        output if_done, dm_done, rdata, busy,
               mem_address, mem_write_enable, mem_read_enable, mem_write_data
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_read_data,
        input  if_done, dm_done, rdata, busy,
               mem_address, mem_write_enable, mem_read_enable, mem_write_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency data memory between the instruction-fetch
// path and the load/store path. One access at a time, alternating priority on
// conflict, read data returned with a one-cycle done pulse to the winner.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t            state;
    state_t            state_next;
    owner_t            owner;
    owner_t            last_owner;
    owner_t            grant_owner;
    logic              grant;
    logic              last_cycle;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we_q;
    logic              if_done_c;
    logic              dm_done_c;
    logic              mem_we_c;
    logic              mem_re_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant decision, next state and per-state outputs.
    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_owner = OWN_FETCH;
        last_cycle  = 1'b0;
        if_done_c   = 1'b0;
        dm_done_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_re_c    = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless fetch is also asking and data was served last.
                if (bus.dm_req && (!bus.if_req || last_owner == OWN_FETCH)) begin
                    grant       = 1'b1;
                    grant_owner = OWN_DATA;
                    state_next  = ACCESS;
                end else if (bus.if_req) begin
                    grant       = 1'b1;
                    grant_owner = OWN_FETCH;
                    state_next  = ACCESS;
                end
            end
            ACCESS: begin
                mem_we_c = (owner == OWN_DATA) && we_q;
                mem_re_c = !we_q;
                if (cnt == '0) begin
                    last_cycle = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if_done_c  = (owner == OWN_FETCH);
                dm_done_c  = (owner == OWN_DATA);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latching at grant, latency countdown and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_FETCH;
            last_owner <= OWN_FETCH;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
        end else if (grant) begin
            owner <= grant_owner;
            cnt   <= CNT_LOAD;
            if (grant_owner == OWN_DATA) begin
                addr_q  <= bus.dm_addr;
                we_q    <= bus.dm_we;
                wdata_q <= bus.dm_wdata;
            end else begin
                addr_q  <= bus.if_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
            end
        end else if (state == ACCESS) begin
            if (last_cycle) begin
                if (!we_q) begin
                    rdata_q <= bus.mem_read_data;
                end
                last_owner <= owner;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign bus.if_done          = if_done_c;
    assign bus.dm_done          = dm_done_c;
    assign bus.busy             = (state != IDLE);
    assign bus.rdata            = rdata_q;
    assign bus.mem_address      = addr_q;
    assign bus.mem_write_data   = wdata_q;
    assign bus.mem_write_enable = mem_we_c;
    assign bus.mem_read_enable  = mem_re_c;
endmodule
